// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared pipeline types for the ARM core.
// Condition codes, NZCV flag indices and the FlagWrite field encoding.
package arm_pipe_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagWrite: bit1 updates N,Z; bit0 updates C,V
    localparam int FW_NZ_BIT = 1;
    localparam int FW_CV_BIT = 0;
    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_CV   = 2'b01;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } m_ctrl_t;

endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against the NZCV flags.
module cond_check
    import arm_pipe_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       CondExE
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondExE = 1'b0;
        case (cond_t'(CondE))
            EQ: CondExE = z;
            NE: CondExE = ~z;
            CS: CondExE = c;
            CC: CondExE = ~c;
            MI: CondExE = n;
            PL: CondExE = ~n;
            VS: CondExE = v;
            VC: CondExE = ~v;
            HI: CondExE = c & ~z;
            LS: CondExE = ~c | z;
            GE: CondExE = n == v;
            LT: CondExE = n != v;
            GT: CondExE = ~z & (n == v);
            LE: CondExE = z | (n != v);
            AL: CondExE = 1'b1;
            NV: CondExE = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_e.sv
// cond_unit_e: execute-stage condition unit, NZCV register and E->M pipeline register.
// Optional COND_UNIT_FLUSHM_EN adds FlushM, which bubbles the E->M register.
module cond_unit_e
    import arm_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef COND_UNIT_FLUSHM_EN
    input  logic             FlushM,
`endif
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic             NoWriteE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [3:0]       WA3E,
    output logic             BranchTakenE,
    output logic             CondExE,
    output logic [3:0]       Flags,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M
);

    logic [3:0]       flags_d, flags_q;
    m_ctrl_t          ctrl_d, ctrl_q;
    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic [WIDTH-1:0] write_data_d, write_data_q;
    logic [3:0]       wa3_d, wa3_q;
    logic             flush;

`ifdef COND_UNIT_FLUSHM_EN
    assign flush = FlushM;
`else
    assign flush = 1'b0;
`endif

    // Condition is always judged on the registered flags, never this cycle's ALU flags
    cond_check u_cond_check (
        .CondE   (CondE),
        .Flags   (flags_q),
        .CondExE (CondExE)
    );

    assign BranchTakenE = BranchE & CondExE;

    always_comb begin
        flags_d = flags_q;
        if (FlagWriteE[FW_NZ_BIT] & CondExE)
            flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
        if (FlagWriteE[FW_CV_BIT] & CondExE)
            flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
        ctrl_d = flush ? '0 : m_ctrl_t'{
            pcsrc:    PCSrcE & CondExE,
            regwrite: RegWriteE & CondExE & ~NoWriteE,
            memtoreg: MemtoRegE,
            memwrite: MemWriteE & CondExE
        };
        alu_result_d = flush ? '0 : ALUResultE;
        write_data_d = flush ? '0 : WriteDataE;
        wa3_d        = flush ? '0 : WA3E;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q      <= '0;
            ctrl_q       <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            wa3_q        <= '0;
        end else begin
            flags_q      <= flags_d;
            ctrl_q       <= ctrl_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            wa3_q        <= wa3_d;
        end
    end

    assign Flags      = flags_q;
    assign PCSrcM     = ctrl_q.pcsrc;
    assign RegWriteM  = ctrl_q.regwrite;
    assign MemtoRegM  = ctrl_q.memtoreg;
    assign MemWriteM  = ctrl_q.memwrite;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign WA3M       = wa3_q;

endmodule

// File: tb/tb_cond_unit_e.sv
// tb_cond_unit_e: randomized self-checking bench for cond_unit_e against a behavioural model.
module tb_cond_unit_e;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         FlushM;
    logic         PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, NoWriteE;
    logic [1:0]   FlagWriteE;
    logic [3:0]   CondE, ALUFlags, WA3E;
    logic [W-1:0] ALUResultE, WriteDataE;
    logic         BranchTakenE, CondExE;
    logic [3:0]   Flags, WA3M;
    logic         PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [W-1:0] ALUResultM, WriteDataM;

    int tests = 0;
    int fails = 0;

    logic [3:0]      mflags;
    logic [2*W+7:0]  exp_m;
    logic [2*W+7:0]  got_m;

    assign got_m = {PCSrcM, RegWriteM, MemtoRegM, MemWriteM, WA3M, ALUResultM, WriteDataM};

    always #5 clk = ~clk;

    cond_unit_e #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef COND_UNIT_FLUSHM_EN
        .FlushM       (FlushM),
`endif
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemtoRegE    (MemtoRegE),
        .MemWriteE    (MemWriteE),
        .BranchE      (BranchE),
        .NoWriteE     (NoWriteE),
        .FlagWriteE   (FlagWriteE),
        .CondE        (CondE),
        .ALUFlags     (ALUFlags),
        .ALUResultE   (ALUResultE),
        .WriteDataE   (WriteDataE),
        .WA3E         (WA3E),
        .BranchTakenE (BranchTakenE),
        .CondExE      (CondExE),
        .Flags        (Flags),
        .PCSrcM       (PCSrcM),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .MemWriteM    (MemWriteM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .WA3M         (WA3M)
    );

    // ARM pairs conditions: even code tests a base predicate, odd code is its inverse
    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cf = f[1];
        bit v = f[0];
        bit base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] == 1'b0;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic randomize_in();
        {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, NoWriteE} = 6'($urandom);
        FlagWriteE = 2'($urandom);
        CondE      = 4'($urandom);
        ALUFlags   = 4'($urandom);
        WA3E       = 4'($urandom);
        ALUResultE = $urandom;
        WriteDataE = $urandom;
        FlushM     = 1'b0;
    endtask

    task automatic clear_ctrl();
        {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, NoWriteE} = '0;
        FlagWriteE = 2'b00;
        CondE      = 4'b1110;
        FlushM     = 1'b0;
    endtask

    // Advance one edge and update the model from the inputs present at that edge
    task automatic tick();
        bit cx = cond_ok(CondE, mflags);
        bit fl = 1'b0;
        logic [3:0] nf = mflags;
        logic [2*W+7:0] nm;
`ifdef COND_UNIT_FLUSHM_EN
        fl = FlushM;
`endif
        if (FlagWriteE[1] && cx) nf[3:2] = ALUFlags[3:2];
        if (FlagWriteE[0] && cx) nf[1:0] = ALUFlags[1:0];
        nm = {PCSrcE && cx, RegWriteE && cx && !NoWriteE, MemtoRegE, MemWriteE && cx,
              WA3E, ALUResultE, WriteDataE};
        if (fl) nm = '0;
        @(posedge clk);
        #1;
        mflags = nf;
        exp_m  = nm;
    endtask

    task automatic set_flags(input logic [3:0] f);
        clear_ctrl();
        FlagWriteE = 2'b11;
        ALUFlags   = f;
        tick();
        tests++;
        if (Flags !== f) begin
            fails++;
            $display("FAIL set_flags got=%b exp=%b", Flags, f);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        randomize_in();
        mflags = '0;
        exp_m  = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            randomize_in();
        end
        tests++;
        if (Flags !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=0000", Flags);
        end
        tests++;
        if (got_m !== '0) begin
            fails++;
            $display("FAIL reset_m got=%h exp=0", got_m);
        end
        clear_ctrl();
        RegWriteE  = 1'b1;
        ALUResultE = 32'h5;
        reset = 1'b1;
        tick();
        tests++;
        if (RegWriteM !== 1'b1 || ALUResultM !== 32'h5) begin
            fails++;
            $display("FAIL reset_release got=%b/%h exp=1/00000005", RegWriteM, ALUResultM);
        end
    endtask

    task automatic test_cmp();
        clear_ctrl();
        FlagWriteE = 2'b11;
        NoWriteE   = 1'b1;
        RegWriteE  = 1'b1;
        ALUFlags   = 4'b0100;
        tick();
        tests++;
        if (RegWriteM !== 1'b0 || Flags !== 4'b0100) begin
            fails++;
            $display("FAIL cmp got=%b/%b exp=0/0100", RegWriteM, Flags);
        end
        clear_ctrl();
        BranchE = 1'b1;
        CondE   = 4'b0000;
        #1;
        tests++;
        if (BranchTakenE !== 1'b1) begin
            fails++;
            $display("FAIL beq_taken got=%b exp=1", BranchTakenE);
        end
        CondE = 4'b0001;
        #1;
        tests++;
        if (BranchTakenE !== 1'b0) begin
            fails++;
            $display("FAIL bne_not_taken got=%b exp=0", BranchTakenE);
        end
        tick();
    endtask

    task automatic test_split_write();
        set_flags(4'b1111);
        clear_ctrl();
        FlagWriteE = 2'b10;
        ALUFlags   = 4'b0000;
        tick();
        tests++;
        if (Flags !== 4'b0011) begin
            fails++;
            $display("FAIL split_nz got=%b exp=0011", Flags);
        end
        clear_ctrl();
        FlagWriteE = 2'b01;
        ALUFlags   = 4'b1100;
        tick();
        tests++;
        if (Flags !== 4'b0000) begin
            fails++;
            $display("FAIL split_cv got=%b exp=0000", Flags);
        end
    endtask

    task automatic test_failed_cond();
        set_flags(4'b0000);
        clear_ctrl();
        CondE      = 4'b0000;
        MemWriteE  = 1'b1;
        PCSrcE     = 1'b1;
        FlagWriteE = 2'b11;
        ALUFlags   = 4'b1111;
        tick();
        tests++;
        if (MemWriteM !== 1'b0 || PCSrcM !== 1'b0 || Flags !== 4'b0000) begin
            fails++;
            $display("FAIL failed_cond got=%b/%b/%b exp=0/0/0000", MemWriteM, PCSrcM, Flags);
        end
    endtask

    task automatic test_signed();
        logic [3:0] codes [6];
        logic       want  [6];
        codes = '{4'b1010, 4'b1011, 4'b1100, 4'b1011, 4'b1101, 4'b1111};
        want  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_flags(4'b1001);
            if (i == 3) set_flags(4'b1000);
            clear_ctrl();
            CondE = codes[i];
            #1;
            tests++;
            if (CondExE !== want[i]) begin
                fails++;
                $display("FAIL signed_cond%0d cond=%b got=%b exp=%b", i, codes[i], CondExE, want[i]);
            end
        end
    endtask

    task automatic test_bubble();
        set_flags(4'b0100);
        clear_ctrl();
        CondE = 4'b0000;
        ALUFlags = 4'b1011;
        tick();
        tests++;
        if ({PCSrcM, RegWriteM, MemtoRegM, MemWriteM} !== 4'b0000 || Flags !== 4'b0100) begin
            fails++;
            $display("FAIL bubble got=%b/%b exp=0000/0100",
                     {PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, Flags);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            randomize_in();
            #1;
            tests++;
            if (CondExE !== cond_ok(CondE, mflags) || BranchTakenE !== (BranchE && cond_ok(CondE, mflags))) begin
                fails++;
                $display("FAIL rand_cond%0d cond=%b flags=%b got=%b/%b", i, CondE, mflags, CondExE, BranchTakenE);
            end
            tick();
            tests++;
            if (Flags !== mflags || got_m !== exp_m) begin
                fails++;
                $display("FAIL rand_state%0d got=%b/%h exp=%b/%h", i, Flags, got_m, mflags, exp_m);
            end
        end
    endtask

    task automatic test_async_reset();
        set_flags(4'b1011);
        randomize_in();
        reset = 1'b0;
        #2;
        tests++;
        if (Flags !== 4'b0000 || got_m !== '0) begin
            fails++;
            $display("FAIL async_reset got=%b/%h exp=0000/0", Flags, got_m);
        end
        mflags = '0;
        exp_m  = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

`ifdef COND_UNIT_FLUSHM_EN
    task automatic test_flush();
        clear_ctrl();
        FlushM     = 1'b1;
        RegWriteE  = 1'b1;
        ALUResultE = 32'hABCD;
        FlagWriteE = 2'b11;
        ALUFlags   = 4'b1010;
        tick();
        tests++;
        if (got_m !== '0 || Flags !== 4'b1010) begin
            fails++;
            $display("FAIL flush got=%h/%b exp=0/1010", got_m, Flags);
        end
        FlushM = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_cmp();
        test_split_write();
        test_failed_cond();
        test_signed();
        test_bubble();
`ifdef COND_UNIT_FLUSHM_EN
        test_flush();
`endif
        test_back_to_back();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
